data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Responder side of the CPU MEM-stage data port: accepts load/store requests, owns the data array, returns read data/acks.
// - Valid/ready request channel in; valid/ready response channel out.
// - Fixed read latency; a response FIFO absorbs CPU backpressure. Replaces the zero-latency combinational data memory.
// PARAMETERS
// - DEPTH       1024  words in data array (power of 2); ADDR_W = $clog2(DEPTH)
// - LATENCY     2     cycles from request accept to response entering FIFO (>=1)
// - FIFO_DEPTH  4     response FIFO entries (power of 2, >= LATENCY)
// PORTS
// - clk        in   1   clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - req_valid  in   1   request present
// - req_ready  out  1   responder can accept a request this cycle
// - req_we     in   1   1 = store, 0 = load
// - req_addr   in   32  byte address
// - req_wdata  in   32  store data, little-endian lanes
// - req_be     in   4   byte enables for stores; ignored for loads
// - rsp_valid  out  1   response at FIFO head
// - rsp_ready  in   1   CPU consumes response
// - rsp_rdata  out  32  load data; 0 for store acks and errors
// - rsp_err    out  1   request faulted (out of range / misaligned)
// BEHAVIOUR
// - Accept = req_valid & req_ready. At most one request per cycle. Word index = req_addr[ADDR_W+1:2].
// - req_ready = (inflight + fifo_count) < FIFO_DEPTH; credit reserved at accept, so no response is ever dropped.
// - Store: enabled lanes written at the accept edge; ack (rdata=0, err=0) produced like a load.
// - Load: array read at the accept edge; data travels a LATENCY-stage valid/data shift pipe, then pushed into FIFO.
// - Load immediately following a store to same word returns new data; load at accept edge sees stores accepted earlier.
// - Out of range: req_addr[31:ADDR_W+2] != 0 -> no write, rdata=0, err=1, same latency.
// - Responses leave strictly in request order. FIFO push and pop same cycle legal at any occupancy incl. full.
// - rsp_valid = FIFO non-empty; rsp_rdata/rsp_err show head; head stable while rsp_valid & !rsp_ready.
// - Occupancy counter: +1 on accept, -1 on pop, both same cycle -> unchanged; never exceeds FIFO_DEPTH.
// - Reset (async assert, sync release): pipe valids cleared, FIFO empty, counters 0 -> req_ready=1, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0. Array contents NOT reset. Reset mid-operation drops in-flight and queued responses;
//   stores already accepted remain committed.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: access with req_addr[1:0]!=0 -> no write, rdata=0, err=1, normal latency/order.
// - MISALIGN_TRAP_EN undefined: req_addr[1:0] ignored; access proceeds on the containing word; err only for range.
// STRUCTURE
// - Package dmem_pkg: DMEM_DATA_W=32, DMEM_BE_W=4, typedef dmem_rsp_t {logic [31:0] rdata; logic err;}.
// - Sub-module dmem_rsp_fifo (params WIDTH, DEPTH): ptr-based FIFO, push/pop/count/empty/full, async active-low reset.
// - Top: array + write lane logic, LATENCY-deep response pipe, occupancy counter, one dmem_rsp_fifo.
// TESTING
// - Store addr 0x10 wdata 0xDEADBEEF be=4'hF, then load 0x10 -> ack(rdata 0) then rdata 0xDEADBEEF, err 0, LATENCY after accept.
// - Store 0x10 wdata 0x000000AA be=4'b0001 over 0xDEADBEEF, load 0x10 -> 0xDEADBEAA.
// - rsp_ready=0, issue 6 loads back-to-back -> exactly FIFO_DEPTH(4) accepted, req_ready low; release -> 4 responses in order.
// - Load addr 0x0000_1000 (DEPTH=1024) -> rdata 0, err 1; array unchanged.
// - MISALIGN_TRAP_EN: store 0x12 -> err 1, word 0x10 unchanged; undefined: store 0x12 writes word 0x10, err 0.
// - Assert rst_n=0 with 2 in flight and 2 queued -> rsp_valid 0 immediately; after release no stale responses, data kept.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the MEM-stage data memory responder.
// Also provides the byte-lane merge used by the store path.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = 4;

    typedef struct packed {
        logic [DMEM_DATA_W-1:0] rdata;
        logic                   err;
    } dmem_rsp_t;

    // Lane i of the result comes from wdata when be[i] is set, otherwise from old.
    function automatic logic [DMEM_DATA_W-1:0] merge_lanes(
        input logic [DMEM_DATA_W-1:0] old_word,
        input logic [DMEM_DATA_W-1:0] wdata,
        input logic [DMEM_BE_W-1:0]   be
    );
        logic [DMEM_DATA_W-1:0] result;
        result = old_word;
        for (int b = 0; b < DMEM_BE_W; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data port bundle: valid/ready request channel and valid/ready response channel.
// The CPU side uses the master modport, the memory responder uses the slave modport.
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [31:0]            req_addr;
    logic [DMEM_DATA_W-1:0] req_wdata;
    logic [DMEM_BE_W-1:0]   req_be;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DMEM_DATA_W-1:0] rsp_rdata;
    logic                   rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_rsp_fifo.sv
// Pointer-based response FIFO; pointers carry an extra wrap bit to tell full from empty.
// Push and pop in the same cycle are allowed at any occupancy, including full.
module dmem_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : storage[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: fixed-latency load/store with an order-preserving response FIFO.
// Define MISALIGN_TRAP_EN to fault accesses whose address is not word aligned.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              misaligned;
    logic              fault;
    logic              accept;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    logic [LATENCY-1:0] pipe_valid;
    dmem_rsp_t          pipe_rsp [LATENCY];

    dmem_rsp_t          head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    assign word_idx     = bus.req_addr[ADDR_W+1:2];
    assign out_of_range = |bus.req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = |bus.req_addr[1:0];
`else
    logic unused_addr_lo;
    assign misaligned     = 1'b0;
    assign unused_addr_lo = ^bus.req_addr[1:0];
`endif

    assign fault  = out_of_range | misaligned;

    // Credit is taken at accept, so a full count blocks requests even if a pop is pending.
    assign bus.req_ready = (occupancy < OCC_W'(FIFO_DEPTH));
    assign accept        = bus.req_valid & bus.req_ready;
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            mem[word_idx] <= merge_lanes(mem[word_idx], bus.req_wdata, bus.req_be);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Loads sample the array at their accept edge, so they observe every earlier store.
    always_ff @(posedge clk) begin
        pipe_rsp[0].rdata <= (!bus.req_we && !fault) ? mem[word_idx] : '0;
        pipe_rsp[0].err   <= fault;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_rsp[i] <= pipe_rsp[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    dmem_rsp_fifo #(
        .WIDTH ($bits(dmem_rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_valid[LATENCY-1]),
        .push_data (pipe_rsp[LATENCY-1]),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = ^{fifo_count, fifo_full};

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_rdata = head.rdata;
    assign bus.rsp_err   = head.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours MISALIGN_TRAP_EN when defined.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int FD    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if dif();

    data_mem_responder #(
        .DEPTH      (DEPTH),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic        m_ready;
    logic        m_valid;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Architectural meaning of one accepted access; applies stores to the model array.
    function automatic exp_t modelAccess(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be, input int acc);
        exp_t e;
        logic flt;
        int   idx;
        flt = (addr >> ($clog2(DEPTH) + 2)) != 0;
`ifdef MISALIGN_TRAP_EN
        flt = flt || (addr % 4 != 0);
`endif
        idx = (addr / 4) % DEPTH;
        if (!flt && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        e.rdata = (!flt && !we) ? model_mem[idx] : 32'h0;
        e.err   = flt;
        e.acc   = acc;
        return e;
    endfunction

    // Every cycle: compare against the model, then record what the coming edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            m_ready = (exp_q.size() < FD);
            m_valid = (exp_q.size() > 0) && (cycle >= exp_q[0].acc + LAT);
            checkOutput("req_ready", {31'b0, dif.req_ready}, {31'b0, m_ready});
            checkOutput("rsp_valid", {31'b0, dif.rsp_valid}, {31'b0, m_valid});
            if (m_valid) begin
                checkOutput("rsp_rdata", dif.rsp_rdata, exp_q[0].rdata);
                checkOutput("rsp_err", {31'b0, dif.rsp_err}, {31'b0, exp_q[0].err});
                if (dif.rsp_ready) void'(exp_q.pop_front());
            end
            if (dif.req_valid && m_ready) begin
                exp_q.push_back(modelAccess(dif.req_we, dif.req_addr, dif.req_wdata, dif.req_be, cycle + 1));
            end
        end
    end

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output int acc);
        dif.req_valid = 1'b1;
        dif.req_we    = we;
        dif.req_addr  = addr;
        dif.req_wdata = wdata;
        dif.req_be    = be;
        acc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dif.req_ready) begin
                acc = cycle + 1;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept want accept for addr %h", addr);
        end
        @(posedge clk);
        #1;
        dif.req_valid = 1'b0;
    endtask

    task automatic expectRsp(input string name, input logic [31:0] rdata, input logic err, input int acc);
        bit found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dif.rsp_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no response want response", name);
        end else begin
            checkOutput({name, "_rdata"}, dif.rsp_rdata, rdata);
            checkOutput({name, "_err"}, {31'b0, dif.rsp_err}, {31'b0, err});
            if (acc >= 0) checkOutput({name, "_latency"}, 32'(cycle - acc), 32'(LAT));
        end
    endtask

    int          a0, a1, a2, accepted;
    logic [31:0] w10;
    logic [31:0] addr;

    initial begin
        dif.req_valid = 1'b0;
        dif.req_we    = 1'b0;
        dif.req_addr  = '0;
        dif.req_wdata = '0;
        dif.req_be    = '0;
        dif.rsp_ready = 1'b1;

        #12;
        checkOutput("reset_req_ready", {31'b0, dif.req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, dif.rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", dif.rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, dif.rsp_err}, 32'd0);
        syncDrive();
        rst_n = 1'b1;

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, a1);
        expectRsp("store_ack", 32'h0, 1'b0, a0);
        expectRsp("load_full", 32'hDEADBEEF, 1'b0, a1);
        syncDrive();

        applyStimulus(1'b1, 32'h10, 32'h000000AA, 4'b0001, a0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, a1);
        expectRsp("partial_ack", 32'h0, 1'b0, a0);
        expectRsp("load_partial", 32'hDEADBEAA, 1'b0, a1);
        syncDrive();

        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'h0, a0);
        applyStimulus(1'b1, 32'h0000_1010, 32'hFFFFFFFF, 4'hF, a1);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, a2);
        expectRsp("range_load", 32'h0, 1'b1, a0);
        expectRsp("range_store", 32'h0, 1'b1, a1);
        expectRsp("range_unchanged", 32'hDEADBEAA, 1'b0, a2);
        syncDrive();

        applyStimulus(1'b1, 32'h12, 32'h11223344, 4'hF, a0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, a1);
`ifdef MISALIGN_TRAP_EN
        w10 = 32'hDEADBEAA;
        expectRsp("misalign_store", 32'h0, 1'b1, a0);
`else
        w10 = 32'h11223344;
        expectRsp("misalign_store", 32'h0, 1'b0, a0);
`endif
        expectRsp("misalign_word", w10, 1'b0, a1);
        syncDrive();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h20 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, a0);
        end
        repeat (4) syncDrive();

        dif.rsp_ready = 1'b0;
        accepted      = 0;
        dif.req_valid = 1'b1;
        dif.req_we    = 1'b0;
        dif.req_addr  = 32'h20;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dif.req_ready) accepted++;
            syncDrive();
            dif.req_addr = 32'h20 + 32'(4*accepted);
        end
        dif.req_valid = 1'b0;
        checkOutput("backpressure_accepted", 32'(accepted), 32'd4);
        checkOutput("backpressure_ready", {31'b0, dif.req_ready}, 32'd0);
        dif.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expectRsp("backpressure_order", 32'hA000_0000 + 32'(i), 1'b0, -1);
        end
        syncDrive();

        dif.rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, a0);
        applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, a0);
        repeat (3) syncDrive();
        applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, a0);
        applyStimulus(1'b0, 32'h28, 32'h0, 4'h0, a0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", {31'b0, dif.rsp_valid}, 32'd0);
        checkOutput("midrst_rsp_rdata", dif.rsp_rdata, 32'd0);
        checkOutput("midrst_rsp_err", {31'b0, dif.rsp_err}, 32'd0);
        checkOutput("midrst_req_ready", {31'b0, dif.req_ready}, 32'd1);
        syncDrive();
        rst_n = 1'b1;
        dif.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_stale_rsp", {31'b0, dif.rsp_valid}, 32'd0);
        end
        syncDrive();
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, a0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, a1);
        expectRsp("kept_store", 32'hCAFEF00D, 1'b0, a0);
        expectRsp("kept_word", w10, 1'b0, a1);
        syncDrive();

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h40 + 32'(4*i), $urandom, 4'hF, a0);
        end
        for (int i = 0; i < 400; i++) begin
            addr = 32'h40 + 32'(4 * ($urandom % 16));
            if ($urandom % 8 == 0) addr = addr + 32'($urandom % 4);
            if ($urandom % 8 == 0) addr = addr | (32'($urandom_range(1, 32'hFFFFF)) << 12);
            dif.req_valid = ($urandom % 4) != 0;
            dif.req_we    = 1'($urandom % 2);
            dif.req_addr  = addr;
            dif.req_wdata = $urandom;
            dif.req_be    = 4'($urandom % 16);
            dif.rsp_ready = ($urandom % 4) != 0;
            syncDrive();
        end
        dif.req_valid = 1'b0;
        dif.rsp_ready = 1'b1;
        repeat (12) syncDrive();
        checkOutput("drain_rsp_valid", {31'b0, dif.rsp_valid}, 32'd0);
        checkOutput("drain_req_ready", {31'b0, dif.req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
